// File: rtl/secuencia_generador.sv
// ============================================================================
// Module   : secuencia_generador
// Function : MSB-first serial pattern transmitter with tick pacing, repeats,
//            inter-burst gap, abort and start-rejection pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module secuencia_generador #(
    parameter int WIDTH = 8,
    parameter int RW    = 4,
    localparam int LW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             tick,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    input  logic [RW-1:0]    reps,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [LW-1:0] c_WIDTH_L = LW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pat;
    logic [WIDTH-1:0] r_shreg;
    logic [LW-1:0]    r_len;
    logic [LW-1:0]    r_cnt;
    logic [RW-1:0]    r_rep;

    logic [LW-1:0]    w_len_eff;
    logic [WIDTH-1:0] w_aligned;

    // Left-align the pattern so the first bit always sits at the MSB.
    always_comb begin
        w_len_eff = (len > c_WIDTH_L) ? c_WIDTH_L : len;
        w_aligned = pattern << (c_WIDTH_L - w_len_eff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_shreg <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_rep   <= '0;
            w       <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    busy    <= 1'b0;
                    if (start && !abort) begin
                        if (len == '0) begin
                            err <= 1'b1;
                        end else begin
                            r_pat   <= w_aligned;
                            r_len   <= w_len_eff;
                            r_rep   <= reps;
                            r_shreg <= w_aligned << 1;
                            r_cnt   <= w_len_eff - LW'(1);
                            w       <= w_aligned[WIDTH-1];
                            w_valid <= 1'b1;
                            busy    <= 1'b1;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        w       <= 1'b0;
                        w_valid <= 1'b0;
                        busy    <= 1'b0;
                    end else if (tick) begin
                        if (r_cnt != '0) begin
                            w       <= r_shreg[WIDTH-1];
                            r_shreg <= r_shreg << 1;
                            r_cnt   <= r_cnt - LW'(1);
                        end else if (r_rep != '0) begin
                            r_rep   <= r_rep - RW'(1);
                            r_shreg <= r_pat;
                            r_cnt   <= r_len - LW'(1);
                            w       <= 1'b0;
                            w_valid <= 1'b0;
                            r_state <= S_GAP;
                        end else begin
                            w       <= 1'b0;
                            w_valid <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        w       <= 1'b0;
                        w_valid <= 1'b0;
                        busy    <= 1'b0;
                    end else if (tick) begin
                        w       <= r_shreg[WIDTH-1];
                        r_shreg <= r_shreg << 1;
                        w_valid <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
